// File: rtl/dmem_pkg.sv
// dmem_pkg: shared enums, lane masks and alignment helper for the data-memory responder
package dmem_pkg;
    typedef enum logic [1:0] {SD = 2'b00, SW = 2'b01, SH = 2'b10, SB = 2'b11} tam_e;
    typedef enum logic [1:0] {LD = 2'b00, LW = 2'b01, LH = 2'b10, LBU = 2'b11} lim_e;
    typedef enum logic [2:0] {IDLE, RD, MRG, WR, RESP} state_e;
    // byte-lane mask at offset 0, indexed by size code (shared by tam and lim)
    localparam logic [3:0][7:0] LANE_MASK = {8'h01, 8'h03, 8'h0F, 8'hFF};
    // offset bits that must be zero for an access of the given size code
    function automatic logic [2:0] align_mask(input logic [1:0] sz);
        return 3'b111 >> sz;
    endfunction
endpackage

// File: rtl/dmem_lane_extract.sv
// dmem_lane_extract: selects the addressed lane of a 64-bit word and extends it
//   word   - memory word
//   offset - byte offset within the word
//   lim    - load kind (ld/lw/lh/lbu)
//   result - extended load value
module dmem_lane_extract
    import dmem_pkg::*;
(
    input  logic [63:0] word,
    input  logic [2:0]  offset,
    input  logic [1:0]  lim,
    output logic [63:0] result
);
    logic [63:0] w_sh;
    assign w_sh = word >> {offset, 3'b000};
    assign result = lim == LD ? w_sh :
                    lim == LW ? {{32{w_sh[31]}}, w_sh[31:0]} :
                    lim == LH ? {{48{w_sh[15]}}, w_sh[15:0]} :
                                {56'd0, w_sh[7:0]};
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store responder over a synchronous 64-bit word memory
//   clk, rst           - clock, asynchronous active-high reset
//   req_*/addr/wdata   - request handshake and payload; tam = store size, lim = load kind
//   resp_valid/rdata   - one-cycle completion with load data; resp_err = misaligned trap
//   mem_*              - word address, write strobe/data, synchronous read data
//   DMEM_MISALIGN_TRAP_EN - when defined, misaligned requests complete at once with resp_err
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [63:0]       addr,
    input  logic [63:0]       wdata,
    input  logic [1:0]        tam,
    input  logic [1:0]        lim,
    output logic              resp_valid,
    output logic [63:0]       rdata,
    output logic              resp_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);
    state_e      r_state;
    logic        r_write;
    logic        r_err;
    logic [1:0]  r_tam;
    logic [1:0]  r_lim;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;
    logic [1:0]  w_size;
    logic [2:0]  w_amask;
    logic        w_mis;
    logic        w_trap;
    logic [7:0]  w_lanes;
    logic [63:0] w_wsh;
    logic [63:0] w_merge;
    logic [63:0] w_ext;
    assign w_size  = req_write ? tam : lim;
    assign w_amask = align_mask(w_size);
    assign w_mis   = |(addr[2:0] & w_amask);
`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_trap = w_mis;
`else
    assign w_trap = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_tam   <= SD;
            r_lim   <= LD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_write <= req_write;
                    r_tam   <= tam;
                    r_lim   <= lim;
                    // offset bits below the access size are cleared; trapped requests never touch memory
                    r_addr  <= {addr[63:3], addr[2:0] & ~w_amask};
                    r_wdata <= wdata;
                    r_err   <= w_trap;
                    r_rdata <= '0;
                    r_state <= w_trap ? RESP : (req_write && tam == SD) ? WR : RD;
                end
                RD:      r_state <= MRG;
                MRG: begin
                    r_rdata <= r_write ? '0 : w_ext;
                    r_state <= RESP;
                end
                WR:      r_state <= RESP;
                default: r_state <= IDLE;
            endcase
        end
    end
    // merge needs the word read back in MRG, so the write data is formed combinationally there
    assign w_lanes = LANE_MASK[r_tam] << r_addr[2:0];
    assign w_wsh   = r_wdata << {r_addr[2:0], 3'b000};
    for (genvar g = 0; g < 8; g++) begin : g_lane
        assign w_merge[8*g +: 8] = w_lanes[g] ? w_wsh[8*g +: 8] : mem_rdata[8*g +: 8];
    end
    dmem_lane_extract u_extract (
        .word   (mem_rdata),
        .offset (r_addr[2:0]),
        .lim    (r_lim),
        .result (w_ext)
    );
    assign req_ready  = r_state == IDLE;
    assign resp_valid = r_state == RESP;
    assign resp_err   = r_state == RESP && r_err;
    assign rdata      = r_state == RESP ? r_rdata : '0;
    assign mem_addr   = r_addr[MEM_AW+2:3];
    assign mem_we     = r_state == WR || (r_state == MRG && r_write);
    assign mem_wdata  = r_state == WR ? r_wdata : (r_state == MRG && r_write) ? w_merge : '0;
endmodule
